// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with per-cycle mode
// control (hold, shift, rotate, load, clear, invert) and an auto-burst
// engine that repeats a shift/rotate mode for a requested number of steps.
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
    parameter int                 CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_INV  = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       lmode_r;
    logic             done_r;
    logic             step_mode_s;

    // Next register value for one operation of the given mode.
    function automatic logic [WIDTH-1:0] next_q(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             s_msb,
        input logic             s_lsb,
        input logic [WIDTH-1:0] load
    );
        logic [WIDTH-1:0] res;
        case (op)
            MODE_HOLD: res = cur;
            MODE_SHR:  res = {s_msb, cur[WIDTH-1:1]};
            MODE_SHL:  res = {cur[WIDTH-2:0], s_lsb};
            MODE_ROR:  res = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_LOAD: res = load;
            MODE_CLR:  res = {WIDTH{1'b0}};
            MODE_INV:  res = ~cur;
            default:   res = cur;
        endcase
        return res;
    endfunction

    // Only the four shift/rotate modes are eligible for an auto-burst.
    always_comb begin
        step_mode_s = 1'b0;
        if ((mode >= MODE_SHR) && (mode <= MODE_ROL)) begin
            step_mode_s = 1'b1;
        end else begin
            step_mode_s = 1'b0;
        end
    end

    // Register, burst sequencer and done pulse; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r     <= RESET_VAL;
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            lmode_r <= MODE_HOLD;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && step_mode_s) begin
                        if (count != {CNT_W{1'b0}}) begin
                            // The start edge itself performs the first step.
                            q_r     <= next_q(mode, q_r, sin_msb, sin_lsb, d);
                            lmode_r <= mode;
                            cnt_r   <= count - CNT_W'(1);
                            if (count != CNT_W'(1)) begin
                                state_r <= ST_BURST;
                                done_r  <= 1'b0;
                            end else begin
                                done_r  <= 1'b1;
                            end
                        end else begin
                            // Zero-length burst completes immediately.
                            done_r <= 1'b1;
                        end
                    end else begin
                        q_r    <= next_q(mode, q_r, sin_msb, sin_lsb, d);
                        done_r <= 1'b0;
                    end
                end
                ST_BURST: begin
                    // Serial inputs stay live; mode, start and d are ignored.
                    q_r   <= next_q(lmode_r, q_r, sin_msb, sin_lsb, d);
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign q        = q_r;
    assign q_bar    = ~q_r;
    assign sout_msb = q_r[WIDTH-1];
    assign sout_lsb = q_r[0];
    assign busy     = (state_r == ST_BURST);
    assign done     = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: randomized and directed bench for univ_shift_reg with a
// behavioural reference model based on a remaining-step count.
module tb_univ_shift_reg;

    localparam int         W   = 8;
    localparam int         CW  = 4;
    localparam logic [7:0] RV  = 8'hA5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic [W-1:0]  d = 8'h00;
    logic          sin_msb = 1'b0;
    logic          sin_lsb = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] count = 4'd0;
    logic [W-1:0]  q, q_bar;
    logic          sout_msb, sout_lsb, busy, done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] m_q = 8'h00;
    int         m_steps = 0;
    logic [2:0] m_bmode = 3'b000;
    logic       m_done = 1'b0;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .mode(mode), .d(d),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .start(start), .count(count),
        .q(q), .q_bar(q_bar), .sout_msb(sout_msb), .sout_lsb(sout_lsb),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] apply_op(input logic [2:0] op, input logic [7:0] v,
                                            input logic smsb, input logic slsb,
                                            input logic [7:0] dd);
        case (op)
            3'd1:    return (v >> 1) + (smsb ? 8'h80 : 8'h00);
            3'd2:    return 8'((v << 1) + (slsb ? 8'h01 : 8'h00));
            3'd3:    return (v >> 1) + ((v % 8'd2 == 8'd1) ? 8'h80 : 8'h00);
            3'd4:    return 8'((v << 1) + ((v >= 8'h80) ? 8'h01 : 8'h00));
            3'd5:    return dd;
            3'd6:    return 8'h00;
            3'd7:    return 8'hFF - v;
            default: return v;
        endcase
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [7:0] nq;
        nq = 8'hFF - m_q;
        return {m_q, nq, (m_steps > 0), m_done, (m_q >= 8'h80), (m_q % 8'd2 == 8'd1)};
    endfunction

    // Advance the model by one edge from the current inputs, then clock the DUT.
    task automatic tick();
        if (reset) begin
            m_q = RV; m_steps = 0; m_done = 1'b0;
        end else if (m_steps > 0) begin
            m_q = apply_op(m_bmode, m_q, sin_msb, sin_lsb, d);
            m_steps = m_steps - 1;
            m_done = (m_steps == 0);
        end else if (start && mode >= 3'd1 && mode <= 3'd4) begin
            if (count == 4'd0) begin
                m_done = 1'b1;
            end else begin
                m_q = apply_op(mode, m_q, sin_msb, sin_lsb, d);
                m_bmode = mode;
                m_steps = int'(count) - 1;
                m_done = (m_steps == 0);
            end
        end else begin
            m_q = apply_op(mode, m_q, sin_msb, sin_lsb, d);
            m_done = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 3'b000; start = 1'b0;
        tick();
        reset = 1'b0;
        n_vec++;
        if ({q, q_bar, busy, done} !== {8'hA5, 8'h5A, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got q=%h q_bar=%h busy=%b done=%b, expected a5 5a 0 0", q, q_bar, busy, done);
        end
    endtask

    task automatic test_direct_modes();
        logic [2:0] ops [9];
        logic [7:0] exps [9];
        ops  = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd7, 3'd6, 3'd0, 3'd0, 3'd0};
        exps = '{8'h81, 8'h03, 8'h81, 8'h03, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00};
        d = 8'h81; sin_lsb = 1'b1; start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mode = ops[i];
            tick();
            n_vec++;
            if (q !== exps[i] || {q, q_bar, busy, done, sout_msb, sout_lsb} !== exp_vec()) begin
                n_err++;
                $display("FAIL direct[%0d] mode=%b: got q=%h busy=%b done=%b, expected q=%h", i, ops[i], q, busy, done, exps[i]);
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] exps [3];
        logic       ebusy [3];
        exps  = '{8'h02, 8'h04, 8'h08};
        ebusy = '{1'b1, 1'b1, 1'b0};
        mode = 3'd5; d = 8'h01; tick();
        mode = 3'd4; start = 1'b1; count = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            start = 1'b0; mode = 3'd7;
            n_vec++;
            if (q !== exps[i] || busy !== ebusy[i] || done !== (i == 2) ||
                {q, q_bar, busy, done, sout_msb, sout_lsb} !== exp_vec()) begin
                n_err++;
                $display("FAIL burst step %0d: got q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                         i, q, busy, done, exps[i], ebusy[i], (i == 2));
            end
        end
        mode = 3'd0; tick();
        n_vec++;
        if (done !== 1'b0 || q !== 8'h08 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL burst tail: got q=%h busy=%b done=%b, expected 08 0 0", q, busy, done);
        end
    endtask

    task automatic test_boundaries();
        // count=0: no change, single done, never busy
        mode = 3'd5; d = 8'h3C; tick();
        mode = 3'd1; start = 1'b1; count = 4'd0; tick();
        start = 1'b0; mode = 3'd0;
        n_vec++;
        if (q !== 8'h3C || done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL count0: got q=%h busy=%b done=%b, expected 3c 0 1", q, busy, done);
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL count0 tail: got busy=%b done=%b, expected 0 0", busy, done);
        end
        // count=1: one step, done next cycle, never busy
        mode = 3'd3; start = 1'b1; count = 4'd1; tick();
        start = 1'b0; mode = 3'd0;
        n_vec++;
        if (q !== 8'h1E || done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL count1: got q=%h busy=%b done=%b, expected 1e 0 1", q, busy, done);
        end
        // start with load mode is a plain load
        mode = 3'd5; d = 8'hC7; start = 1'b1; count = 4'd5; tick();
        start = 1'b0; mode = 3'd0;
        n_vec++;
        if (q !== 8'hC7 || done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_load: got q=%h busy=%b done=%b, expected c7 0 0", q, busy, done);
        end
    endtask

    task automatic test_serial_stream();
        logic bits [8];
        bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        mode = 3'd1; start = 1'b1; count = 4'd8;
        for (int i = 0; i < 8; i++) begin
            sin_msb = bits[i];
            tick();
            start = 1'b0; mode = 3'd0;
            n_vec++;
            if (sout_lsb !== q[0] || {q, q_bar, busy, done, sout_msb, sout_lsb} !== exp_vec()) begin
                n_err++;
                $display("FAIL serial step %0d: got q=%h sout_lsb=%b busy=%b done=%b, expected %h",
                         i, q, sout_lsb, busy, done, exp_vec());
            end
        end
        n_vec++;
        if (q !== 8'b01001101 || done !== 1'b1) begin
            n_err++;
            $display("FAIL serial final: got q=%b done=%b, expected 01001101 1", q, done);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        mode = 3'd5; d = 8'h01; tick();
        mode = 3'd3; start = 1'b1; count = 4'd15;
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'b0;
        end
        reset = 1'b1; tick(); reset = 1'b0; mode = 3'd0;
        n_vec++;
        if (q !== RV || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got q=%h busy=%b done=%b, expected a5 0 0", q, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== RV) begin
                n_err++;
                $display("FAIL reset_mid tail %0d: got q=%h busy=%b done=%b, expected a5 0 0", i, q, busy, done);
            end
        end
        mode = 3'd4; start = 1'b1; count = 4'd2; tick();
        start = 1'b0; mode = 3'd0;
        n_vec++;
        if (q !== 8'h4B || busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart: got q=%h busy=%b, expected 4b 1", q, busy);
        end
        tick();
        n_vec++;
        if (q !== 8'h96 || busy !== 1'b0 || done !== 1'b1) begin
            n_err++;
            $display("FAIL restart end: got q=%h busy=%b done=%b, expected 96 0 1", q, busy, done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 49) == 0);
            mode    = 3'($urandom_range(0, 7));
            d       = 8'($urandom);
            sin_msb = 1'($urandom);
            sin_lsb = 1'($urandom);
            start   = ($urandom_range(0, 3) == 0);
            count   = 4'($urandom_range(0, 15));
            tick();
            n_vec++;
            if ({q, q_bar, busy, done, sout_msb, sout_lsb} !== exp_vec()) begin
                n_err++;
                $display("FAIL random %0d: got q=%h busy=%b done=%b, expected q=%h busy=%b done=%b",
                         i, q, busy, done, m_q, (m_steps > 0), m_done);
            end
        end
        reset = 1'b0; start = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_direct_modes();
        test_burst();
        test_boundaries();
        test_serial_stream();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
